hnf_data_sram_banked: RTL and testbench
=======================================

// Module: hnf_data_sram_banked
// PURPOSE
// - Banked L3 data array for the HN-F: stores WAY_NUM cache lines per set across BANK_NUM
//   interleaved banks, with byte-granular writes, a valid/ready request port and a
//   fixed-latency read response pipeline.
// - Sits between hnf_cache_pipeline (requests) and hnf_data_buffer (read data).
// - Successor of the single-bank, way-masked data SRAM. Adds bank interleave, per-bank busy
//   (multi-cycle SRAM) throttling, byte enables and a configurable read latency.
// PARAMETERS
// - INDEX_WIDTH  10   set index width; bank = index[BANK_BITS-1:0], row = index[INDEX_WIDTH-1:BANK_BITS]
// - WAY_NUM      16   ways per set; one line per way
// - LINE_WIDTH   512  cache line bits; multiple of 8; BE_WIDTH = LINE_WIDTH/8
// - BANK_NUM     4    power of 2, 1..16; BANK_BITS = clog2(BANK_NUM); 1 means one bank
// - BANK_CYC     2    cycles a bank stays occupied per access, 1..4
// - RD_LAT       2    accept-to-response latency, 1..4
// PORTS
// - clk        in   1             clock
// - rst        in   1             asynchronous reset, active-high
// - req_valid  in   1             request present
// - req_ready  out  1             request accepted this cycle if req_valid & req_ready
// - req_write  in   1             1 = write, 0 = read
// - req_index  in   INDEX_WIDTH   set index
// - req_ways   in   WAY_NUM       way select; write: every set bit is written; read: selected ways OR-combined
// - req_be     in   BE_WIDTH      write byte enables; ignored on read
// - req_data   in   LINE_WIDTH    write data
// - rsp_valid  out  1             read data valid; no backpressure
// - rsp_data   out  LINE_WIDTH    read data; 0 whenever rsp_valid = 0
// BEHAVIOUR
// - One clock (clk). Reset is asynchronous and active-high (rst). rst clears busy counters and
//   the read pipeline. Array contents are not reset.
// - Reset values: req_ready = 1, rsp_valid = 0, rsp_data = 0.
// - req_ready = (busy_cnt[bank(req_index)] == 0). It is combinational from req_index and
//   independent of req_valid and req_write.
// - On accept: busy_cnt[bank] <= BANK_CYC-1. Each cycle, every nonzero counter decrements.
// - BANK_CYC = 1 allows back-to-back access to any bank.
// - Accepts to different banks in consecutive cycles are always allowed.
// - Write (accepted at cycle T): for each way w with req_ways[w] set, byte k of line (row, w)
//   is updated where req_be[k] = 1. The update is visible to any read accepted at T+1 or later.
// - Write with req_ways = 0 or req_be = 0 is accepted, occupies the bank, and changes no data.
// - Read (accepted at cycle T): rsp_valid = 1 at exactly T+RD_LAT for one cycle.
// - Read data: rsp_data = OR over w with req_ways[w] set of line(row, w). req_ways = 0 gives
//   rsp_valid = 1 with rsp_data = 0.
// - Read pipeline: array read registered at T+1, then RD_LAT-1 valid/data stages. Reads return
//   in acceptance order, at most one response per cycle (one accept per cycle).
// - Writes produce no response.
// - rst asserted mid-operation: all in-flight reads are dropped (rsp_valid low from the reset
//   edge) and counters clear. A write accepted in the reset cycle is not guaranteed.
// - req_valid = 0: no state change except counter decrement and pipeline shift.
// STRUCTURE
// - Shared package hnf_defines.v: BANK_BITS/BE_WIDTH derivation macros and the clog2 helper.
//   Reuse the existing LOC_INDEX_WIDTH, LOC_WAY_NUM and CACHE_LINE_WIDTH as defaults.
// - Sub-module hnf_data_bank: one bank.
//   - Ports: clk, we, ways, be, row, wdata, rdata_ways.
//   - Storage: 2**(INDEX_WIDTH-BANK_BITS) x WAY_NUM x LINE_WIDTH, byte-writable.
//   - Registered read of all ways.
//   - Instantiated BANK_NUM times via generate.
// - Top level holds the busy counters, ready logic, bank-select register, way OR-select and
//   RD_LAT pipeline.
// TESTING
// - Write idx 0x005, ways 0x0001, be all 1s, data 0xA5 repeated; later read idx 0x005,
//   ways 0x0001 -> rsp_valid exactly RD_LAT cycles after accept, rsp_data = 0xA5 repeated.
// - Partial write: be = 0x...0001, data byte0 = 0x3C over the line above; read ->
//   byte0 = 0x3C, bytes 1..63 = 0xA5.
// - BANK_CYC = 2: accept idx 0x004 (bank 0), next cycle present idx 0x008 (bank 0) ->
//   req_ready = 0 for 1 cycle, accepted the cycle after. Idx 0x005 (bank 1) instead ->
//   accepted immediately.
// - Back-to-back reads to banks 0, 1, 2, 3 on consecutive cycles -> 4 consecutive rsp_valid
//   pulses, data in request order, none lost.
// - Broadcast write ways 0x8001, data D; read ways 0x8000 -> D. Read ways 0 -> rsp_valid = 1,
//   rsp_data = 0.
// - Assert rst with 2 reads in flight -> rsp_valid stays 0, req_ready = 1 after release.
//   Data written before reset reads back unchanged.

Source files
------------

// File: rtl/hnf_data_sram_banked_pkg.sv
// Shared defaults and parameter helpers for the banked HN-F data array.
// Pure constants and functions; no latency, no flow control.
// Imported by the interface, the bank and the top level.
package hnf_data_sram_banked_pkg;

    localparam int LOC_INDEX_WIDTH  = 10;
    localparam int LOC_WAY_NUM      = 16;
    localparam int CACHE_LINE_WIDTH = 512;

    // Holds BANK_CYC-1, and BANK_CYC never exceeds 4.
    localparam int BUSY_W = 2;
    typedef logic [BUSY_W-1:0] busy_cnt_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int bank_bits(input int bank_num);
        return clog2(bank_num);
    endfunction

    function automatic int be_width(input int line_width);
        return line_width / 8;
    endfunction

endpackage

// File: rtl/hnf_data_sram_banked_if.sv
// Request/response bundle between the cache pipeline and the banked data array.
// Signal container only; no latency.
// Request side is valid/ready; response side has no backpressure.
interface hnf_data_sram_banked_if
    import hnf_data_sram_banked_pkg::*;
#(
    parameter int INDEX_WIDTH = LOC_INDEX_WIDTH,
    parameter int WAY_NUM     = LOC_WAY_NUM,
    parameter int LINE_WIDTH  = CACHE_LINE_WIDTH
);
    localparam int BE_WIDTH = be_width(LINE_WIDTH);

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [WAY_NUM-1:0]     req_ways;
    logic [BE_WIDTH-1:0]    req_be;
    logic [LINE_WIDTH-1:0]  req_data;
    logic                   rsp_valid;
    logic [LINE_WIDTH-1:0]  rsp_data;

    modport master (
        output req_valid, req_write, req_index, req_ways, req_be, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_index, req_ways, req_be, req_data,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/hnf_data_sram_banked_bank.sv
// One data bank: all ways of a row, byte-writable, read of every way registered.
// Latency: write lands at the clock edge, read data one cycle after the row is presented.
// No flow control; the top level throttles access.
module hnf_data_bank #(
    parameter int ROW_WIDTH  = 8,
    parameter int WAY_NUM    = 16,
    parameter int LINE_WIDTH = 512
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [WAY_NUM-1:0]                 ways,
    input  logic [LINE_WIDTH/8-1:0]            be,
    input  logic [ROW_WIDTH-1:0]               row,
    input  logic [LINE_WIDTH-1:0]              wdata,
    output logic [WAY_NUM-1:0][LINE_WIDTH-1:0] rdata_ways
);
    localparam int DEPTH    = 1 << ROW_WIDTH;
    localparam int BE_WIDTH = LINE_WIDTH / 8;

    logic [LINE_WIDTH-1:0] mem [DEPTH][WAY_NUM];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                for (int k = 0; k < BE_WIDTH; k++) begin
                    if (ways[w] && be[k]) begin
                        mem[row][w][k*8 +: 8] <= wdata[k*8 +: 8];
                    end
                end
            end
        end
        for (int w = 0; w < WAY_NUM; w++) begin
            rdata_ways[w] <= mem[row][w];
        end
    end

endmodule

// File: rtl/hnf_data_sram_banked.sv
// Banked L3 data array: index-interleaved banks, byte writes, way-OR read select.
// Latency: read response exactly RD_LAT cycles after accept; writes give no response.
// Backpressure: req_ready drops while the addressed bank is busy; responses are never stalled.
module hnf_data_sram_banked
    import hnf_data_sram_banked_pkg::*;
#(
    parameter int INDEX_WIDTH = LOC_INDEX_WIDTH,
    parameter int WAY_NUM     = LOC_WAY_NUM,
    parameter int LINE_WIDTH  = CACHE_LINE_WIDTH,
    parameter int BANK_NUM    = 4,
    parameter int BANK_CYC    = 2,
    parameter int RD_LAT      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    hnf_data_sram_banked_if.slave  bus
);
    localparam int BANK_BITS = bank_bits(BANK_NUM);
    localparam int BSEL_W    = (BANK_BITS == 0) ? 1 : BANK_BITS;
    localparam int ROW_WIDTH = INDEX_WIDTH - BANK_BITS;

    logic [BSEL_W-1:0]    req_bank;
    logic [ROW_WIDTH-1:0] req_row;
    logic                 accept;
    busy_cnt_t            busy_cnt [BANK_NUM];

    assign req_bank = BSEL_W'(bus.req_index & INDEX_WIDTH'(BANK_NUM - 1));
    assign req_row  = ROW_WIDTH'(bus.req_index >> BANK_BITS);

    assign bus.req_ready = (busy_cnt[req_bank] == '0);
    assign accept        = bus.req_valid & bus.req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                busy_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < BANK_NUM; b++) begin
                if (accept && (req_bank == BSEL_W'(b))) begin
                    busy_cnt[b] <= busy_cnt_t'(BANK_CYC - 1);
                end else if (busy_cnt[b] != '0) begin
                    busy_cnt[b] <= busy_cnt[b] - 1'b1;
                end
            end
        end
    end

    logic [WAY_NUM-1:0][LINE_WIDTH-1:0] bank_rdata [BANK_NUM];

    // Every bank reads the presented row each cycle; only the selected one is used.
    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        hnf_data_bank #(
            .ROW_WIDTH  (ROW_WIDTH),
            .WAY_NUM    (WAY_NUM),
            .LINE_WIDTH (LINE_WIDTH)
        ) u_bank (
            .clk        (clk),
            .we         (accept && bus.req_write && (req_bank == BSEL_W'(b))),
            .ways       (bus.req_ways),
            .be         (bus.req_be),
            .row        (req_row),
            .wdata      (bus.req_data),
            .rdata_ways (bank_rdata[b])
        );
    end

    logic               s1_vld;
    logic [BSEL_W-1:0]  s1_bank;
    logic [WAY_NUM-1:0] s1_ways;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_bank <= '0;
            s1_ways <= '0;
        end else begin
            s1_vld  <= accept & ~bus.req_write;
            s1_bank <= req_bank;
            s1_ways <= bus.req_ways;
        end
    end

    logic [LINE_WIDTH-1:0] sel_dat;

    always_comb begin
        sel_dat = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (s1_ways[w]) begin
                sel_dat = sel_dat | bank_rdata[s1_bank][w];
            end
        end
        if (!s1_vld) begin
            sel_dat = '0;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign bus.rsp_valid = s1_vld;
        assign bus.rsp_data  = sel_dat;
    end else begin : g_latn
        logic [RD_LAT-2:0]     pipe_vld;
        logic [LINE_WIDTH-1:0] pipe_dat [RD_LAT-1];

        // Data is zeroed in idle slots upstream, so the stages carry zero between responses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_vld <= '0;
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    pipe_dat[i] <= '0;
                end
            end else begin
                pipe_vld[0] <= s1_vld;
                pipe_dat[0] <= sel_dat;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    pipe_vld[i] <= pipe_vld[i-1];
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end

        assign bus.rsp_valid = pipe_vld[RD_LAT-2];
        assign bus.rsp_data  = pipe_dat[RD_LAT-2];
    end

endmodule

// File: tb/tb_hnf_data_sram_banked.sv
// Directed bench for the banked data array: latency, byte writes, bank throttling, reset.
// Expected read data and response cycles are hand-written per request.
module tb_hnf_data_sram_banked;

    localparam int IW       = 10;
    localparam int WN       = 16;
    localparam int LW       = 512;
    localparam int BW       = LW / 8;
    localparam int BANK_NUM = 4;
    localparam int BANK_CYC = 2;
    localparam int RD_LAT   = 2;

    localparam logic [LW-1:0] LINE_A5   = {64{8'hA5}};
    localparam logic [LW-1:0] LINE_PART = {{63{8'hA5}}, 8'h3C};
    localparam logic [LW-1:0] LINE_D    = {16{32'hDEADBEEF}};

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_err;

    int              exp_cyc_q [$];
    logic [LW-1:0]   exp_dat_q [$];
    string           exp_tag_q [$];

    hnf_data_sram_banked_if #(.INDEX_WIDTH(IW), .WAY_NUM(WN), .LINE_WIDTH(LW)) bus ();

    hnf_data_sram_banked #(
        .INDEX_WIDTH (IW),
        .WAY_NUM     (WN),
        .LINE_WIDTH  (LW),
        .BANK_NUM    (BANK_NUM),
        .BANK_CYC    (BANK_CYC),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest outstanding read, on its cycle.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_cyc_q.size() == 0) begin
                check("stray_rsp", LW'(1), LW'(0));
            end else begin
                check({exp_tag_q[0], "_cycle"}, LW'(cyc), LW'(exp_cyc_q[0]));
                check({exp_tag_q[0], "_data"}, bus.rsp_data, exp_dat_q[0]);
                void'(exp_cyc_q.pop_front());
                void'(exp_dat_q.pop_front());
                void'(exp_tag_q.pop_front());
            end
        end else begin
            if (bus.rsp_data !== '0) begin
                check("rsp_data_idle", bus.rsp_data, '0);
            end
            if (exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc) begin
                check({exp_tag_q[0], "_missing"}, LW'(0), LW'(1));
                void'(exp_cyc_q.pop_front());
                void'(exp_dat_q.pop_front());
                void'(exp_tag_q.pop_front());
            end
        end
    end

    task automatic drive(input bit wr, input logic [IW-1:0] idx, input logic [WN-1:0] ways,
                         input logic [BW-1:0] be, input logic [LW-1:0] dat);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_index = idx;
        bus.req_ways  = ways;
        bus.req_be    = be;
        bus.req_data  = dat;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit wr, input logic [IW-1:0] idx, input logic [WN-1:0] ways,
                        input logic [BW-1:0] be, input logic [LW-1:0] dat,
                        input logic [LW-1:0] exp, input string tag);
        int n;
        drive(wr, idx, ways, be, dat);
        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            check({tag, "_accept_timeout"}, LW'(bus.req_ready), LW'(1));
        end else if (!wr) begin
            exp_cyc_q.push_back(cyc + RD_LAT);
            exp_dat_q.push_back(exp);
            exp_tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_index = '0;
        bus.req_ways  = '0;
        bus.req_be    = '0;
        bus.req_data  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", LW'(bus.req_ready), LW'(1));
        check("rst_rsp_valid", LW'(bus.rsp_valid), LW'(0));
        check("rst_rsp_data", bus.rsp_data, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full write then read; partial byte write then read.
        send(1'b1, 10'h005, 16'h0001, '1, LINE_A5, '0, "wr_a5");
        send(1'b0, 10'h005, 16'h0001, '0, '0, LINE_A5, "rd_a5");
        send(1'b1, 10'h005, 16'h0001, BW'(1), LW'(8'h3C), '0, "wr_part");
        send(1'b0, 10'h005, 16'h0001, '0, '0, LINE_PART, "rd_part");
        repeat (3) @(posedge clk);
        #1;

        // Bank throttling with zero-enable writes that must leave data alone.
        drive(1'b1, 10'h004, 16'h0001, '0, '1);
        @(negedge clk);
        check("rdy_bank0_idle", LW'(bus.req_ready), LW'(1));
        @(posedge clk);
        #1;
        bus.req_index = 10'h008;
        @(negedge clk);
        check("rdy_bank0_busy", LW'(bus.req_ready), LW'(0));
        bus.req_valid = 1'b0;
        #1;
        check("rdy_busy_no_valid", LW'(bus.req_ready), LW'(0));
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rdy_bank0_free", LW'(bus.req_ready), LW'(1));
        @(posedge clk);
        #1;
        bus.req_index = 10'h005;
        @(negedge clk);
        check("rdy_bank1_idle", LW'(bus.req_ready), LW'(1));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        send(1'b0, 10'h005, 16'h0001, '0, '0, LINE_PART, "rd_be0_nochange");

        // Back-to-back reads across all four banks.
        send(1'b1, 10'h010, 16'h0002, '1, {64{8'h10}}, '0, "wr_b0");
        send(1'b1, 10'h011, 16'h0002, '1, {64{8'h21}}, '0, "wr_b1");
        send(1'b1, 10'h012, 16'h0002, '1, {64{8'h32}}, '0, "wr_b2");
        send(1'b1, 10'h013, 16'h0002, '1, {64{8'h43}}, '0, "wr_b3");
        send(1'b0, 10'h010, 16'h0002, '0, '0, {64{8'h10}}, "rd_b0");
        send(1'b0, 10'h011, 16'h0002, '0, '0, {64{8'h21}}, "rd_b1");
        send(1'b0, 10'h012, 16'h0002, '0, '0, {64{8'h32}}, "rd_b2");
        send(1'b0, 10'h013, 16'h0002, '0, '0, {64{8'h43}}, "rd_b3");

        // Broadcast write, single-way reads, empty way mask, OR of two ways.
        send(1'b1, 10'h020, 16'h8001, '1, LINE_D, '0, "wr_bcast");
        send(1'b0, 10'h020, 16'h8000, '0, '0, LINE_D, "rd_bcast_w15");
        send(1'b0, 10'h020, 16'h0001, '0, '0, LINE_D, "rd_bcast_w0");
        send(1'b0, 10'h020, 16'h0000, '0, '0, '0, "rd_ways_zero");
        send(1'b1, 10'h021, 16'h0001, '1, {64{8'h0F}}, '0, "wr_or0");
        send(1'b1, 10'h021, 16'h0002, '1, {64{8'hF0}}, '0, "wr_or1");
        send(1'b0, 10'h021, 16'h0003, '0, '0, {64{8'hFF}}, "rd_or");
        repeat (4) @(posedge clk);
        #1;

        // Reset with two reads in flight: both are dropped.
        send(1'b0, 10'h020, 16'h8000, '0, '0, LINE_D, "rd_drop0");
        send(1'b0, 10'h005, 16'h0001, '0, '0, LINE_PART, "rd_drop1");
        rst = 1'b1;
        exp_cyc_q.delete();
        exp_dat_q.delete();
        exp_tag_q.delete();
        @(negedge clk);
        check("rst_inflight_valid", LW'(bus.rsp_valid), LW'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.req_index = 10'h008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", LW'(bus.rsp_valid), LW'(0));
        end
        check("post_rst_ready", LW'(bus.req_ready), LW'(1));
        @(posedge clk);
        #1;
        send(1'b0, 10'h020, 16'h8000, '0, '0, LINE_D, "rd_after_rst_d");
        send(1'b0, 10'h005, 16'h0001, '0, '0, LINE_PART, "rd_after_rst_part");

        for (int i = 0; i < 20 && exp_cyc_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_cyc_q.size() != 0) begin
            check("drain_timeout", LW'(exp_cyc_q.size()), LW'(0));
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
